fsm_stream_arbiter: RTL and testbench

Round-robin scheduler that shares one serial 3-state Mealy engine (states A/B/C, input x, outputs y/z) among N requesters. Each requester submits a bit stream and its length. The block grants one requester at a time and feeds the stream LSB-first through the engine, which restarts in state A for every job. It then returns the captured y/z output streams and the final engine state. It sits between the per-channel stimulus sources and the result collectors in the sequence-detection path.

---
 rtl/fsm_stream_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_fsm_stream_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_stream_arbiter.sv
// fsm_stream_arbiter: round-robin scheduler sharing one serial 3-state Mealy
// engine (A/B/C, input x, outputs y/z) among N requesters. Each granted job
// streams its data LSB-first through the engine, which starts in A for every
// job, and returns the captured y/z streams plus the final engine state.
// Optional feature: define FSA_ABORT_EN to add the 'abort' input, which
// cancels a running job without a done pulse.
module fsm_stream_arbiter #(
  parameter int N      = 4,
  parameter int MAXLEN = 8,
  localparam int LW    = $clog2(MAXLEN + 1),
  localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FSA_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [N-1:0]          req,
  input  logic [N*LW-1:0]       req_len,
  input  logic [N*MAXLEN-1:0]   req_data,
  output logic [N-1:0]          ack,
  output logic                  busy,
  output logic                  done,
  output logic [IW-1:0]         res_id,
  output logic [MAXLEN-1:0]     res_y,
  output logic [MAXLEN-1:0]     res_z,
  output logic [LW-1:0]         res_len,
  output logic [1:0]            res_st
);

  // Bit counter only needs to address bits 0..MAXLEN-1
  localparam int CW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  // Engine state encoding; 2'b10 is illegal and recovers to A
  localparam logic [1:0] ST_A = 2'b00;
  localparam logic [1:0] ST_B = 2'b01;
  localparam logic [1:0] ST_C = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } ctrl_e;

  ctrl_e               state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [MAXLEN-1:0]   data_q, data_d;
  logic [LW-1:0]       len_q, len_d;
  logic [IW-1:0]       id_q, id_d;
  logic [1:0]          eng_q, eng_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [MAXLEN-1:0]   ry_q, ry_d;
  logic [MAXLEN-1:0]   rz_q, rz_d;
  logic [N-1:0]        ack_q, ack_d;

  logic                gnt_found;
  logic [IW-1:0]       gnt_idx;
  logic [IW-1:0]       cand;
  logic [LW-1:0]       len_in;
  logic [LW-1:0]       len_cl;
  logic [3:0]          step;
  logic                abort_w;

`ifdef FSA_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // One engine step: returns {next_state, y, z}
  function automatic logic [3:0] eng_step(input logic [1:0] st, input logic x);
    logic [3:0] r;
    case (st)
      ST_A:    r = x ? {ST_C, 2'b11} : {ST_B, 2'b01};
      ST_B:    r = x ? {ST_C, 2'b10} : {ST_B, 2'b10};
      ST_C:    r = x ? {ST_C, 2'b01} : {ST_A, 2'b10};
      default: r = {ST_A, 2'b00};
    endcase
    return r;
  endfunction

  // Round-robin search: first asserted request at or above ptr, with wrap
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Operand length of the candidate, clamped to MAXLEN
  always_comb begin
    len_in = req_len[int'(gnt_idx)*LW +: LW];
    len_cl = (len_in > LW'(MAXLEN)) ? LW'(MAXLEN) : len_in;
  end

  // Controller next state plus datapath updates (grant, bit step, abort)
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    len_d   = len_q;
    id_d    = id_q;
    eng_d   = eng_q;
    cnt_d   = cnt_q;
    ry_d    = ry_q;
    rz_d    = rz_q;
    ack_d   = '0;
    step    = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          ack_d[gnt_idx] = 1'b1;
          ptr_d   = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
          data_d  = req_data[int'(gnt_idx)*MAXLEN +: MAXLEN];
          len_d   = len_cl;
          id_d    = gnt_idx;
          eng_d   = ST_A;
          cnt_d   = '0;
          ry_d    = '0;
          rz_d    = '0;
          state_d = (len_cl == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort_w) begin
          // Partial results stay visible; ptr already moved at grant
          state_d = S_IDLE;
        end else begin
          step        = eng_step(eng_q, data_q[cnt_q]);
          eng_d       = step[3:2];
          ry_d[cnt_q] = step[1];
          rz_d[cnt_q] = step[0];
          cnt_d       = cnt_q + CW'(1);
          if (LW'(cnt_q) == len_q - LW'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration pointer, job operands, engine and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= '0;
      data_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
      eng_q  <= ST_A;
      cnt_q  <= '0;
      ry_q   <= '0;
      rz_q   <= '0;
      ack_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      data_q <= data_d;
      len_q  <= len_d;
      id_q   <= id_d;
      eng_q  <= eng_d;
      cnt_q  <= cnt_d;
      ry_q   <= ry_d;
      rz_q   <= rz_d;
      ack_q  <= ack_d;
    end
  end

  assign ack     = ack_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign res_id  = id_q;
  assign res_y   = ry_q;
  assign res_z   = rz_q;
  assign res_len = len_q;
  assign res_st  = eng_q;

endmodule

// File: tb/tb_fsm_stream_arbiter.sv
// Testbench for fsm_stream_arbiter: table-driven jobs, hand-written corner
// sequences (round-robin order, mid-job reset, optional abort) and random
// traffic checked against a job-level behavioural model.
module tb_fsm_stream_arbiter;

  localparam int N      = 4;
  localparam int MAXLEN = 8;
  localparam int LW     = 4;
  localparam int IW     = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N-1:0]        req = '0;
  logic [N*LW-1:0]     req_len = '0;
  logic [N*MAXLEN-1:0] req_data = '0;
  logic [N-1:0]        ack;
  logic                busy;
  logic                done;
  logic [IW-1:0]       res_id;
  logic [MAXLEN-1:0]   res_y;
  logic [MAXLEN-1:0]   res_z;
  logic [LW-1:0]       res_len;
  logic [1:0]          res_st;
`ifdef FSA_ABORT_EN
  logic                abort = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  fsm_stream_arbiter #(.N(N), .MAXLEN(MAXLEN)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef FSA_ABORT_EN
    .abort    (abort),
`endif
    .req      (req),
    .req_len  (req_len),
    .req_data (req_data),
    .ack      (ack),
    .busy     (busy),
    .done     (done),
    .res_id   (res_id),
    .res_y    (res_y),
    .res_z    (res_z),
    .res_len  (res_len),
    .res_st   (res_st)
  );

  always #5 clk = ~clk;

  // Reference engine as lookup tables; state index 0=A, 1=B, 2=C
  int         nxt_t [3][2] = '{'{1, 2}, '{1, 2}, '{0, 2}};
  bit         y_t   [3][2] = '{'{1'b0, 1'b1}, '{1'b1, 1'b1}, '{1'b1, 1'b0}};
  bit         z_t   [3][2] = '{'{1'b1, 1'b1}, '{1'b0, 1'b0}, '{1'b0, 1'b1}};
  logic [1:0] enc_t [3]    = '{2'b00, 2'b01, 2'b11};

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] z;
    logic [1:0] st;
    logic [3:0] len;
  } res_t;

  typedef struct {
    int         id;
    int         len;
    logic [7:0] data;
    logic [7:0] ey;
    logic [7:0] ez;
    logic [1:0] est;
    logic [3:0] elen;
  } vec_t;

  function automatic res_t model(input int len, input logic [7:0] d);
    res_t r;
    int   s;
    int   l;
    int   x;
    r = '0;
    s = 0;
    l = (len > MAXLEN) ? MAXLEN : len;
    for (int k = 0; k < l; k++) begin
      x = int'(d[k]);
      r.y[k] = y_t[s][x];
      r.z[k] = z_t[s][x];
      s = nxt_t[s][x];
    end
    r.st  = enc_t[s];
    r.len = 4'(l);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic set_job(input int i, input int len, input logic [7:0] d);
    req_len[i*LW +: LW]         = LW'(len);
    req_data[i*MAXLEN +: MAXLEN] = d;
  endtask

  // Single-requester job from IDLE with exact timing checks
  task automatic run_job(input int i, input int len, input logic [7:0] d, output res_t got);
    int le;
    le = (len > MAXLEN) ? MAXLEN : len;
    set_job(i, len, d);
    req[i] = 1'b1;
    tick();
    chk("job_ack", 32'(ack), 32'(1 << i));
    chk("job_busy", 32'(busy), 32'd1);
    req[i] = 1'b0;
    for (int c = 1; c <= le; c++) begin
      tick();
      if (c < le) chk("job_done_early", 32'(done), 32'd0);
    end
    chk("job_done", 32'(done), 32'd1);
    chk("job_res_id", 32'(res_id), 32'(i));
    got = {res_y, res_z, res_st, res_len};
    tick();
    chk("job_done_pulse", 32'(done), 32'd0);
    chk("job_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       vt [6];
    res_t       g;
    res_t       m;
    logic [N-1:0] pend;
    int         lens [N];
    logic [7:0] datas [N];
    int         mp;
    int         ei;
    int         edges;
    int         j;

    vt[0] = '{0, 3,  8'h03, 8'h05, 8'h03, 2'b00, 4'd3};
    vt[1] = '{2, 2,  8'h00, 8'h02, 8'h01, 2'b01, 4'd2};
    vt[2] = '{1, 0,  8'hA5, 8'h00, 8'h00, 2'b00, 4'd0};
    vt[3] = '{3, 15, 8'hFF, 8'h01, 8'hFF, 2'b11, 4'd8};
    vt[4] = '{1, 1,  8'h01, 8'h01, 8'h01, 2'b11, 4'd1};
    vt[5] = '{2, 4,  8'h0A, 8'h0E, 8'h09, 2'b11, 4'd4};

    // Reset state
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'({res_y, res_z, res_len, res_st, res_id}), 32'd0);
    rst = 1'b1;
    tick();

    // Table-driven single jobs
    for (int v = 0; v < 6; v++) begin
      run_job(vt[v].id, vt[v].len, vt[v].data, g);
      chk("tv_y", 32'(g.y), 32'(vt[v].ey));
      chk("tv_z", 32'(g.z), 32'(vt[v].ez));
      chk("tv_st", 32'(g.st), 32'(vt[v].est));
      chk("tv_len", 32'(g.len), 32'(vt[v].elen));
    end

    // Round-robin with all requests held, len 1 each
    do_reset();
    for (int i = 0; i < N; i++) set_job(i, 1, 8'h00);
    req = '1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_ack", 32'(ack), 32'(1 << (k % N)));
      tick();
      chk("rr_done", 32'(done), 32'd1);
      chk("rr_id", 32'(res_id), 32'(k % N));
      if (k == 4) req = '0;
      tick();
      chk("rr_gap", 32'({ack, done}), 32'd0);
    end

    // Reset while running at bit 2, then re-grant from ptr 0
    do_reset();
    set_job(1, 5, 8'h5A);
    set_job(3, 2, 8'h01);
    req = 4'b1010;
    tick();
    chk("mr_ack", 32'(ack), 32'h2);
    tick();
    tick();
    chk("mr_partial_y", 32'(res_y), 32'h2);
    rst = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_ack0", 32'(ack), 32'd0);
    chk("mr_res_y", 32'(res_y), 32'd0);
    rst = 1'b1;
    tick();
    chk("mr_regrant", 32'(ack), 32'h2);
    req[1] = 1'b0;
    m = model(5, 8'h5A);
    for (int c = 1; c <= 5; c++) tick();
    chk("mr_job_done", 32'(done), 32'd1);
    chk("mr_job_res", 32'({res_y, res_z, res_st, res_len}), 32'(m));
    tick();
    tick();
    chk("mr_next_ack", 32'(ack), 32'h8);
    req = '0;
    m = model(2, 8'h01);
    tick();
    tick();
    chk("mr_next_done", 32'(done), 32'd1);
    chk("mr_next_res", 32'({res_y, res_z, res_st, res_len}), 32'(m));
    tick();

`ifdef FSA_ABORT_EN
    // Abort in the second RUN cycle of a len 5 job
    do_reset();
    set_job(1, 5, 8'hFF);
    set_job(2, 1, 8'h00);
    req = 4'b0110;
    tick();
    chk("ab_ack", 32'(ack), 32'h2);
    req[1] = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_idle", 32'({busy, done}), 32'd0);
    tick();
    chk("ab_next_ack", 32'(ack), 32'h4);
    req = '0;
    tick();
    chk("ab_next_done", 32'(done), 32'd1);
    tick();
`endif

    // Random traffic against the job-level model
    do_reset();
    pend = '0;
    mp   = 0;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          lens[i]  = int'($urandom_range(0, 10));
          datas[i] = 8'($urandom);
          set_job(i, lens[i], datas[i]);
          pend[i] = 1'b1;
        end
      end
      if (pend == '0) begin
        j = int'($urandom_range(0, N - 1));
        lens[j]  = int'($urandom_range(0, 10));
        datas[j] = 8'($urandom);
        set_job(j, lens[j], datas[j]);
        pend[j] = 1'b1;
      end
      req = pend;
      ei = -1;
      for (int k = 0; k < N; k++) begin
        j = (mp + k) % N;
        if (ei < 0 && pend[j]) ei = j;
      end
      for (int w = 0; w < 6; w++) begin
        tick();
        if (ack != '0) break;
      end
      chk("rnd_ack", 32'(ack), 32'(1 << ei));
      pend[ei] = 1'b0;
      req = pend;
      mp = (ei + 1) % N;
      m = model(lens[ei], datas[ei]);
      edges = 0;
      while (!done && edges < MAXLEN + 2) begin
        tick();
        edges++;
      end
      chk("rnd_latency", 32'(edges), 32'(m.len));
      chk("rnd_id", 32'(res_id), 32'(ei));
      chk("rnd_res", 32'({res_y, res_z, res_st, res_len}), 32'(m));
    end
    req = '0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
